// File: rtl/ps2_keyboard_fifo.sv
// rtl/ps2_keyboard_fifo.sv - PS/2 keyboard receiver with E0/F0 prefix decode and key-event FIFO
// Frames are checked for start/parity/stop; completed key events fall through a FWFT queue.
module ps2_keyboard_fifo #(
  parameter int FIFO_DEPTH     = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int CNT_W          = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             CLK_CPU,
  input  logic             resetp,
  input  logic             keyboard_clock,
  input  logic             keyboard_data,
  input  logic             clean_key_buffer,
  input  logic             flush,
  output logic [7:0]       pressed_key,
  output logic             key_break,
  output logic             key_extended,
  output logic             keyboard_valid,
  output logic [CNT_W-1:0] fill_level,
  output logic             overflow,
  output logic             parity_error,
  output logic             frame_error
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  // Synchronisers idle high so reset never fabricates a falling edge.
  logic [SYNC_STAGES-1:0] kclk_sync_q;
  logic [SYNC_STAGES-1:0] kdat_sync_q;
  logic                   kclk_prev_q;
  logic                   fall;
  logic                   din;

  always_ff @(posedge CLK_CPU) begin
    if (resetp) begin
      kclk_sync_q <= '1;
      kdat_sync_q <= '1;
      kclk_prev_q <= 1'b1;
    end else begin
      kclk_sync_q <= {kclk_sync_q[SYNC_STAGES-2:0], keyboard_clock};
      kdat_sync_q <= {kdat_sync_q[SYNC_STAGES-2:0], keyboard_data};
      kclk_prev_q <= kclk_sync_q[SYNC_STAGES-1];
    end
  end

  assign fall = kclk_prev_q & ~kclk_sync_q[SYNC_STAGES-1];
  assign din  = kdat_sync_q[SYNC_STAGES-1];

  logic [1:0]      state_q, state_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            ext_q, ext_d;
  logic            brk_q, brk_d;
  logic            perr_q, perr_d;
  logic            ferr_q, ferr_d;
  logic            push;
  logic [9:0]      push_data;

  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    to_cnt_d  = to_cnt_q;
    ext_d     = ext_q;
    brk_d     = brk_q;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    push      = 1'b0;
    push_data = {ext_q, brk_q, shift_q};

    if (fall) begin
      to_cnt_d = '0;
      case (state_q)
        S_IDLE: begin
          if (!din) begin
            state_d  = S_DATA;
            bitcnt_d = 3'd0;
          end else begin
            ferr_d = 1'b1;
            ext_d  = 1'b0;
            brk_d  = 1'b0;
          end
        end
        S_DATA: begin
          shift_d  = {din, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            state_d = S_PARITY;
          end
        end
        S_PARITY: begin
          par_d   = din;
          state_d = S_STOP;
        end
        default: begin
          state_d = S_IDLE;
          // A bad stop bit outranks a parity failure.
          if (!din) begin
            ferr_d = 1'b1;
            ext_d  = 1'b0;
            brk_d  = 1'b0;
          end else if (!(^{shift_q, par_q})) begin
            perr_d = 1'b1;
            ext_d  = 1'b0;
            brk_d  = 1'b0;
          end else if (shift_q == 8'hE0) begin
            ext_d = 1'b1;
          end else if (shift_q == 8'hF0) begin
            brk_d = 1'b1;
          end else begin
            push  = 1'b1;
            ext_d = 1'b0;
            brk_d = 1'b0;
          end
        end
      endcase
    end else if (state_q != S_IDLE) begin
      if (to_cnt_q == TO_LAST) begin
        state_d  = S_IDLE;
        to_cnt_d = '0;
        ferr_d   = 1'b1;
        ext_d    = 1'b0;
        brk_d    = 1'b0;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end else begin
      to_cnt_d = '0;
    end

    if (flush) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end
  end

  always_ff @(posedge CLK_CPU) begin
    if (resetp) begin
      state_q  <= S_IDLE;
      bitcnt_q <= 3'd0;
      shift_q  <= 8'h00;
      par_q    <= 1'b0;
      to_cnt_q <= '0;
      ext_q    <= 1'b0;
      brk_q    <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      to_cnt_q <= to_cnt_d;
      ext_q    <= ext_d;
      brk_q    <= brk_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
    end
  end

  logic [9:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             full, empty;
  logic             do_push, do_pop;
  logic [9:0]       head;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign do_pop  = clean_key_buffer & ~empty & ~flush;
  // A pop at full frees the slot the simultaneous push lands in.
  assign do_push = push & (~full | do_pop) & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        count_d = count_q - CNT_W'(1);
      end
      if (push && !do_push) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK_CPU) begin
    if (resetp) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge CLK_CPU) begin
    if (do_push && !resetp) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head           = mem_q[rd_ptr_q];
  assign pressed_key    = empty ? 8'h00 : head[7:0];
  assign key_break      = ~empty & head[8];
  assign key_extended   = ~empty & head[9];
  assign keyboard_valid = ~empty;
  assign fill_level     = count_q;
  assign overflow       = ovf_q;
  assign parity_error   = perr_q;
  assign frame_error    = ferr_q;

endmodule

// File: tb/tb_ps2_keyboard_fifo.sv
// tb/tb_ps2_keyboard_fifo.sv - scoreboard bench for ps2_keyboard_fifo
module tb_ps2_keyboard_fifo;

  localparam int DEPTH = 8;
  localparam int SYNC  = 2;
  localparam int TMO   = 300;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int H     = 8;

  logic          clk = 1'b0;
  logic          resetp = 1'b1;
  logic          kb_clk = 1'b1;
  logic          kb_data = 1'b1;
  logic          clean = 1'b0;
  logic          flush = 1'b0;
  logic [7:0]    pressed_key;
  logic          key_break;
  logic          key_extended;
  logic          keyboard_valid;
  logic [CW-1:0] fill_level;
  logic          overflow;
  logic          parity_error;
  logic          frame_error;

  int vectors = 0;
  int miscompares = 0;
  int perr_cnt = 0;
  int ferr_cnt = 0;
  logic [9:0] exp_q[$];
  logic [9:0] exp;

  ps2_keyboard_fifo #(
    .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO), .CNT_W(CW)
  ) dut (
    .CLK_CPU(clk), .resetp(resetp), .keyboard_clock(kb_clk), .keyboard_data(kb_data),
    .clean_key_buffer(clean), .flush(flush), .pressed_key(pressed_key),
    .key_break(key_break), .key_extended(key_extended), .keyboard_valid(keyboard_valid),
    .fill_level(fill_level), .overflow(overflow), .parity_error(parity_error),
    .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (parity_error) perr_cnt++;
    if (frame_error) ferr_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] code, input bit bad_par, input bit bad_stop, input int nbits);
    logic [10:0] fr;
    fr = {~bad_stop, (~^code) ^ bad_par, code, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      kb_data = fr[i];
      tick(H);
      kb_clk = 1'b0;
      tick(H);
      kb_clk = 1'b1;
    end
    tick(H);
  endtask

  task automatic pop_pulse();
    clean = 1'b1;
    tick(1);
    clean = 1'b0;
  endtask

  task automatic test_reset();
    tick(3);
    vectors++;
    if ({keyboard_valid, pressed_key, key_break, key_extended, overflow, parity_error, frame_error} !== 13'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h expected 0", {keyboard_valid, pressed_key, key_break, key_extended, overflow, parity_error, frame_error});
    end
    vectors++;
    if (fill_level !== '0) begin
      miscompares++;
      $display("FAIL reset_fill: got %0d expected 0", fill_level);
    end
    resetp = 1'b0;
    tick(2);
  endtask

  task automatic test_single();
    send_bits(8'h1C, 0, 0, 10);
    kb_data = 1'b1;
    tick(H);
    kb_clk = 1'b0;
    tick(SYNC);
    vectors++;
    if (keyboard_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_early: valid got %b expected 0", keyboard_valid);
    end
    tick(1);
    vectors++;
    if ({keyboard_valid, key_extended, key_break, pressed_key} !== {1'b1, 2'b00, 8'h1C}) begin
      miscompares++;
      $display("FAIL single_head: got %h expected %h", {keyboard_valid, key_extended, key_break, pressed_key}, {1'b1, 2'b00, 8'h1C});
    end
    vectors++;
    if (fill_level !== CW'(1)) begin
      miscompares++;
      $display("FAIL single_fill: got %0d expected 1", fill_level);
    end
    tick(H);
    kb_clk = 1'b1;
    tick(H);
    pop_pulse();
    vectors++;
    if ({keyboard_valid, pressed_key} !== 9'd0) begin
      miscompares++;
      $display("FAIL single_pop: got %h expected 0", {keyboard_valid, pressed_key});
    end
  endtask

  task automatic test_prefix();
    send_bits(8'hE0, 0, 0, 11);
    send_bits(8'hF0, 0, 0, 11);
    send_bits(8'h75, 0, 0, 11);
    exp_q.push_back({2'b11, 8'h75});
    vectors++;
    if (fill_level !== CW'(1)) begin
      miscompares++;
      $display("FAIL prefix_fill: got %0d expected 1", fill_level);
    end
    send_bits(8'h75, 0, 0, 11);
    exp_q.push_back({2'b00, 8'h75});
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      vectors++;
      if ({key_extended, key_break, pressed_key} !== exp) begin
        miscompares++;
        $display("FAIL prefix_event: got %h expected %h", {key_extended, key_break, pressed_key}, exp);
      end
      pop_pulse();
    end
  endtask

  task automatic test_parity();
    int p0;
    int f0;
    send_bits(8'hE0, 0, 0, 11);
    p0 = perr_cnt;
    f0 = ferr_cnt;
    send_bits(8'h1C, 1, 0, 11);
    vectors++;
    if (perr_cnt - p0 !== 1 || ferr_cnt - f0 !== 0) begin
      miscompares++;
      $display("FAIL parity_pulse: got perr=%0d ferr=%0d expected 1 0", perr_cnt - p0, ferr_cnt - f0);
    end
    vectors++;
    if (fill_level !== '0) begin
      miscompares++;
      $display("FAIL parity_fill: got %0d expected 0", fill_level);
    end
    send_bits(8'hF0, 0, 0, 11);
    send_bits(8'h1C, 0, 0, 11);
    exp_q.push_back({2'b01, 8'h1C});
    exp = exp_q.pop_front();
    vectors++;
    if ({keyboard_valid, key_extended, key_break, pressed_key} !== {1'b1, exp}) begin
      miscompares++;
      $display("FAIL parity_next: got %h expected %h", {keyboard_valid, key_extended, key_break, pressed_key}, {1'b1, exp});
    end
    pop_pulse();
    f0 = ferr_cnt;
    send_bits(8'h1C, 0, 1, 11);
    vectors++;
    if (ferr_cnt - f0 !== 1 || fill_level !== '0) begin
      miscompares++;
      $display("FAIL bad_stop: got ferr=%0d fill=%0d expected 1 0", ferr_cnt - f0, fill_level);
    end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 9; i++) begin
      send_bits(8'(i), 0, 0, 11);
      if (i <= DEPTH) exp_q.push_back({2'b00, 8'(i)});
    end
    vectors++;
    if ({fill_level, overflow} !== {CW'(DEPTH), 1'b1}) begin
      miscompares++;
      $display("FAIL ovf_full: got fill=%0d ovf=%b expected %0d 1", fill_level, overflow, DEPTH);
    end
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      vectors++;
      if ({key_extended, key_break, pressed_key} !== exp) begin
        miscompares++;
        $display("FAIL ovf_order: got %h expected %h", {key_extended, key_break, pressed_key}, exp);
      end
      pop_pulse();
    end
    pop_pulse();
    vectors++;
    if ({keyboard_valid, fill_level, overflow} !== {1'b0, CW'(0), 1'b1}) begin
      miscompares++;
      $display("FAIL ovf_drained: got %h expected %h", {keyboard_valid, fill_level, overflow}, {1'b0, CW'(0), 1'b1});
    end
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    vectors++;
    if (overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_ovf: got %b expected 0", overflow);
    end
    for (int i = 0; i < DEPTH; i++) begin
      send_bits(8'h11 + 8'(i), 0, 0, 11);
      exp_q.push_back({2'b00, 8'h11 + 8'(i)});
    end
    send_bits(8'h19, 0, 0, 10);
    kb_data = 1'b1;
    tick(H);
    kb_clk = 1'b0;
    tick(SYNC);
    exp = exp_q.pop_front();
    vectors++;
    if ({fill_level, pressed_key} !== {CW'(DEPTH), exp[7:0]}) begin
      miscompares++;
      $display("FAIL full_head: got %h expected %h", {fill_level, pressed_key}, {CW'(DEPTH), exp[7:0]});
    end
    exp_q.push_back({2'b00, 8'h19});
    pop_pulse();
    vectors++;
    if ({fill_level, overflow} !== {CW'(DEPTH), 1'b0}) begin
      miscompares++;
      $display("FAIL push_pop_full: got fill=%0d ovf=%b expected %0d 0", fill_level, overflow, DEPTH);
    end
    tick(H);
    kb_clk = 1'b1;
    tick(H);
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      vectors++;
      if ({keyboard_valid, key_extended, key_break, pressed_key} !== {1'b1, exp}) begin
        miscompares++;
        $display("FAIL full_order: got %h expected %h", {keyboard_valid, key_extended, key_break, pressed_key}, {1'b1, exp});
      end
      pop_pulse();
    end
  endtask

  task automatic test_timeout();
    int f0;
    f0 = ferr_cnt;
    send_bits(8'h2A, 0, 0, 5);
    tick(TMO + 20);
    vectors++;
    if (ferr_cnt - f0 !== 1) begin
      miscompares++;
      $display("FAIL timeout_pulse: got %0d expected 1", ferr_cnt - f0);
    end
    send_bits(8'h2A, 0, 0, 11);
    vectors++;
    if ({fill_level, key_extended, key_break, pressed_key} !== {CW'(1), 2'b00, 8'h2A}) begin
      miscompares++;
      $display("FAIL timeout_next: got %h expected %h", {fill_level, key_extended, key_break, pressed_key}, {CW'(1), 2'b00, 8'h2A});
    end
    pop_pulse();
  endtask

  task automatic test_reset_midframe();
    send_bits(8'h21, 0, 0, 11);
    send_bits(8'h22, 0, 0, 11);
    send_bits(8'h23, 0, 0, 11);
    send_bits(8'hE0, 0, 0, 11);
    vectors++;
    if (fill_level !== CW'(3)) begin
      miscompares++;
      $display("FAIL pre_reset_fill: got %0d expected 3", fill_level);
    end
    send_bits(8'h44, 0, 0, 5);
    resetp = 1'b1;
    tick(1);
    vectors++;
    if ({keyboard_valid, fill_level, pressed_key, key_break, key_extended, overflow, parity_error, frame_error} !== '0) begin
      miscompares++;
      $display("FAIL midframe_reset: got %h expected 0", {keyboard_valid, fill_level, pressed_key, key_break, key_extended, overflow, parity_error, frame_error});
    end
    resetp = 1'b0;
    tick(2);
    send_bits(8'h33, 0, 0, 11);
    vectors++;
    if ({fill_level, key_extended, key_break, pressed_key} !== {CW'(1), 2'b00, 8'h33}) begin
      miscompares++;
      $display("FAIL after_reset: got %h expected %h", {fill_level, key_extended, key_break, pressed_key}, {CW'(1), 2'b00, 8'h33});
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_prefix();
    test_parity();
    test_overflow();
    test_timeout();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
